reg_file_param: RTL and testbench

- Parametrised successor to the 8x8 processor register file.
- Generalises data width and depth, and adds optional same-cycle write-to-read forwarding and an optional hardwired-zero register 0.
- Adds a debug dump engine that streams every register, in order, over a valid/ready handshake.
- Sits in the CPU datapath between decode (register addresses) and the ALU, with the dump port wired to the debug/trace logic.

---
 rtl/reg_file_param.sv | 145 ++++++++++++++
 tb/tb_reg_file_param.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with optional write-to-read
// forwarding, optional hardwired-zero register 0 and a debug dump engine.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous active-low reset
//   WRITEDATA    write data
//   WRITEREG     write address
//   WRITEENABLE  write strobe
//   READREG1/2   read addresses
//   REGOUT1/2    combinational read data
//   DUMP_START   dump request (accepted while idle)
//   DUMP_READY   dump consumer ready
//   DUMP_VALID   dump beat valid
//   DUMP_ADDR    address of presented beat
//   DUMP_DATA    data of presented beat
//   DUMP_BUSY    dump in progress
//   DUMP_DONE    one-cycle pulse after the last beat is accepted
module reg_file_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    input  logic [ADDR_WIDTH-1:0] WRITEREG,
    input  logic                  WRITEENABLE,
    input  logic [ADDR_WIDTH-1:0] READREG1,
    input  logic [ADDR_WIDTH-1:0] READREG2,
    output logic [DATA_WIDTH-1:0] REGOUT1,
    output logic [DATA_WIDTH-1:0] REGOUT2,
    input  logic                  DUMP_START,
    input  logic                  DUMP_READY,
    output logic                  DUMP_VALID,
    output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
    output logic [DATA_WIDTH-1:0] DUMP_DATA,
    output logic                  DUMP_BUSY,
    output logic                  DUMP_DONE
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
    logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
    logic                  dump_done_q, dump_done_d;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] fwd_sel;
    logic [DATA_WIDTH-1:0] fwd_val;

    // Writes to the zero register are dropped here, so regs_q[0] stays at
    // its reset value and every read/dump path sees 0 without extra muxing.
    always_comb begin
        wr_en = WRITEENABLE && !((ZERO_REG != 0) && (WRITEREG == '0));
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WRITEREG] = WRITEDATA;
        end
    end

    always_comb begin
        REGOUT1 = regs_q[READREG1];
        REGOUT2 = regs_q[READREG2];
        if ((BYPASS != 0) && wr_en && (WRITEREG == READREG1)) begin
            REGOUT1 = WRITEDATA;
        end
        if ((BYPASS != 0) && wr_en && (WRITEREG == READREG2)) begin
            REGOUT2 = WRITEDATA;
        end
    end

    // The beat loaded at an edge must reflect that edge's write, so the dump
    // always forwards, independent of BYPASS.
    always_comb begin
        fwd_sel = (state_q == IDLE) ? '0 : dump_addr_q + 1'b1;
        fwd_val = (wr_en && (WRITEREG == fwd_sel)) ? WRITEDATA : regs_q[fwd_sel];
    end

    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        dump_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (DUMP_START) begin
                    state_d     = SEND;
                    dump_addr_d = '0;
                    dump_data_d = fwd_val;
                end
            end
            SEND: begin
                if (DUMP_READY) begin
                    if (dump_addr_q == '1) begin
                        state_d     = IDLE;
                        dump_done_d = 1'b1;
                    end else begin
                        dump_addr_d = dump_addr_q + 1'b1;
                        dump_data_d = fwd_val;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            regs_q      <= '{default: '0};
            state_q     <= IDLE;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            dump_done_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            state_q     <= state_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
            dump_done_q <= dump_done_d;
        end
    end

    always_comb begin
        DUMP_VALID = (state_q == SEND);
        DUMP_BUSY  = (state_q == SEND);
        DUMP_ADDR  = dump_addr_q;
        DUMP_DATA  = dump_data_q;
        DUMP_DONE  = dump_done_q;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: checks two configurations of reg_file_param
// (A: 8x8, bypass, no zero reg; B: 16x16, no bypass, zero reg) against a
// behavioural model. Dump beats go through per-instance expected queues
// popped by a negedge monitor.
module tb_reg_file_param;

    logic        CLK;
    logic        RESET;

    logic [7:0]  a_wd, a_o1, a_o2, a_ddata;
    logic [2:0]  a_wr, a_r1, a_r2, a_daddr;
    logic        a_we, a_start, a_ready, a_valid, a_busy, a_done;

    logic [15:0] b_wd, b_o1, b_o2, b_ddata;
    logic [3:0]  b_wr, b_r1, b_r2, b_daddr;
    logic        b_we, b_start, b_ready, b_valid, b_busy, b_done;

    reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .WRITEDATA(a_wd), .WRITEREG(a_wr), .WRITEENABLE(a_we),
        .READREG1(a_r1), .READREG2(a_r2), .REGOUT1(a_o1), .REGOUT2(a_o2),
        .DUMP_START(a_start), .DUMP_READY(a_ready), .DUMP_VALID(a_valid),
        .DUMP_ADDR(a_daddr), .DUMP_DATA(a_ddata), .DUMP_BUSY(a_busy), .DUMP_DONE(a_done)
    );

    reg_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .CLK(CLK), .RESET(RESET), .WRITEDATA(b_wd), .WRITEREG(b_wr), .WRITEENABLE(b_we),
        .READREG1(b_r1), .READREG2(b_r2), .REGOUT1(b_o1), .REGOUT2(b_o2),
        .DUMP_START(b_start), .DUMP_READY(b_ready), .DUMP_VALID(b_valid),
        .DUMP_ADDR(b_daddr), .DUMP_DATA(b_ddata), .DUMP_BUSY(b_busy), .DUMP_DONE(b_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } beat_t;

    beat_t       qa[$];
    beat_t       qb[$];
    logic [15:0] m [2][16];
    int          depth [2] = '{8, 16};
    bit          byp   [2] = '{1'b1, 1'b0};
    bit          zr    [2] = '{1'b0, 1'b1};
    bit          act   [2];
    int          idx   [2];
    bit          dexp  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m[k][i] = '0;
            act[k]  = 1'b0;
            idx[k]  = 0;
            dexp[k] = 1'b0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic push(input int k, input int a, input logic [15:0] d);
        beat_t b;
        b.addr = 4'(a);
        b.data = d;
        if (k == 0) qa.push_back(b);
        else        qb.push_back(b);
    endtask

    // Register contents after an edge, then what the dump presents next.
    task automatic model_step(input int k, input logic we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic st, input logic rdy);
        if (we && !(zr[k] && wa == 0)) m[k][wa] = wd;
        dexp[k] = 1'b0;
        if (!act[k]) begin
            if (st) begin
                act[k] = 1'b1;
                idx[k] = 0;
                push(k, 0, m[k][0]);
            end
        end else if (rdy) begin
            if (idx[k] == depth[k] - 1) begin
                act[k]  = 1'b0;
                dexp[k] = 1'b1;
            end else begin
                idx[k]++;
                push(k, idx[k], m[k][idx[k]]);
            end
        end
    endtask

    function automatic logic [15:0] rdexp(input int k, input logic [3:0] a, input logic we,
                                          input logic [3:0] wa, input logic [15:0] wd);
        if (zr[k] && a == 0) return '0;
        if (byp[k] && we && wa == a && !(zr[k] && wa == 0)) return wd;
        return m[k][a];
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) model_reset();
            else begin
                model_step(0, a_we, 4'(a_wr), 16'(a_wd), a_start, a_ready);
                model_step(1, b_we, b_wr, b_wd, b_start, b_ready);
            end
        end
    end

    // ---------------- monitor ----------------
    task automatic mon(input int k, input logic v, input logic bsy, input logic dn,
                       input logic [3:0] ad, input logic [15:0] dt, input logic rdy);
        beat_t f;
        string p;
        p = (k == 0) ? "A" : "B";
        chk({p, "_valid"}, 32'(v), 32'(act[k]));
        chk({p, "_busy"}, 32'(bsy), 32'(act[k]));
        chk({p, "_done"}, 32'(dn), 32'(dexp[k]));
        if (v) begin
            if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
                chk({p, "_unexpected_beat"}, 32'(ad), 32'hFFFF_FFFF);
            end else begin
                f = (k == 0) ? qa[0] : qb[0];
                chk({p, "_beat_addr"}, 32'(ad), 32'(f.addr));
                chk({p, "_beat_data"}, 32'(dt), 32'(f.data));
                if (rdy) begin
                    if (k == 0) void'(qa.pop_front());
                    else        void'(qb.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                mon(0, a_valid, a_busy, a_done, 4'(a_daddr), 16'(a_ddata), a_ready);
                mon(1, b_valid, b_busy, b_done, b_daddr, b_ddata, b_ready);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [7:0] d);
        a_we = 1'b1; a_wr = a; a_wd = d;
        cyc();
        a_we = 1'b0;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [15:0] d);
        b_we = 1'b1; b_wr = a; b_wd = d;
        cyc();
        b_we = 1'b0;
    endtask

    task automatic chk_reads();
        #1;
        chk("A_rd1", 32'(a_o1), 32'(rdexp(0, 4'(a_r1), a_we, 4'(a_wr), 16'(a_wd))));
        chk("A_rd2", 32'(a_o2), 32'(rdexp(0, 4'(a_r2), a_we, 4'(a_wr), 16'(a_wd))));
        chk("B_rd1", 32'(b_o1), 32'(rdexp(1, b_r1, b_we, b_wr, b_wd)));
        chk("B_rd2", 32'(b_o2), 32'(rdexp(1, b_r2, b_we, b_wr, b_wd)));
    endtask

    int  n;
    bit  w3;

    initial begin
        RESET = 1'b0;
        a_wd = '0; a_wr = '0; a_we = 1'b0; a_r1 = 3'd3; a_r2 = 3'd6; a_start = 1'b0; a_ready = 1'b0;
        b_wd = '0; b_wr = '0; b_we = 1'b0; b_r1 = 4'd9; b_r2 = 4'd15; b_start = 1'b0; b_ready = 1'b0;
        #2;
        chk("reset_A_rd1", 32'(a_o1), 0);
        chk("reset_A_rd2", 32'(a_o2), 0);
        chk("reset_B_rd1", 32'(b_o1), 0);
        chk("reset_A_dump", {a_valid, a_busy, a_done, 5'(a_daddr), a_ddata}, 0);
        chk("reset_B_dump", {b_valid, b_busy, b_done, b_daddr, b_ddata}, 0);
        #2;
        RESET = 1'b1;
        cyc();

        // basic write/read
        wr_a(3'd2, 8'd95);
        a_r1 = 3'd2; #1;
        chk("A_write_read_95", 32'(a_o1), 95);
        wr_a(3'd1, 8'd28);
        a_r2 = 3'd1; #1;
        chk("A_write_read_28", 32'(a_o2), 28);

        // forwarding: A bypasses, B shows the old value until after the edge
        wr_b(4'd4, 16'd3);
        a_we = 1'b1; a_wr = 3'd4; a_wd = 8'd6; a_r1 = 3'd4;
        b_we = 1'b1; b_wr = 4'd4; b_wd = 16'd6; b_r1 = 4'd4;
        #1;
        chk("A_bypass_pre_edge", 32'(a_o1), 6);
        chk("B_nobypass_pre_edge", 32'(b_o1), 3);
        cyc();
        a_we = 1'b0; b_we = 1'b0; #1;
        chk("A_bypass_post_edge", 32'(a_o1), 6);
        chk("B_nobypass_post_edge", 32'(b_o1), 6);

        // zero register and highest address
        wr_a(3'd0, 8'd50);
        wr_b(4'd0, 16'd50);
        a_r1 = 3'd0; b_r1 = 4'd0; #1;
        chk("A_reg0_writable", 32'(a_o1), 50);
        chk("B_reg0_zero", 32'(b_o1), 0);
        wr_a(3'd7, 8'd50);
        wr_b(4'd15, 16'hBEEF);
        a_r2 = 3'd7; b_r2 = 4'd15; #1;
        chk("A_reg7", 32'(a_o2), 50);
        chk("B_reg15_beef", 32'(b_o2), 32'hBEEF);

        // randomized datapath traffic with occasional dumps
        for (int c = 0; c < 300; c++) begin
            a_we = 1'($urandom); a_wr = 3'($urandom); a_wd = 8'($urandom);
            a_r1 = 3'($urandom); a_r2 = ($urandom_range(0, 3) == 0) ? a_wr : 3'($urandom);
            b_we = 1'($urandom); b_wr = 4'($urandom); b_wd = 16'($urandom);
            b_r1 = 4'($urandom); b_r2 = ($urandom_range(0, 3) == 0) ? b_wr : 4'($urandom);
            a_start = ($urandom_range(0, 15) == 0);
            b_start = ($urandom_range(0, 15) == 0);
            a_ready = 1'($urandom); b_ready = 1'($urandom);
            chk_reads();
            cyc();
        end
        a_we = 1'b0; b_we = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_ready = 1'b1; b_ready = 1'b1;
        n = 0;
        while ((a_busy || b_busy) && n < 40) begin cyc(); n++; end
        chk("drain_idle_timeout", 32'(a_busy || b_busy), 0);

        // directed dump with backpressure and writes during the dump
        for (int k = 0; k < 8; k++) wr_a(3'(k), 8'(10 + k));
        a_start = 1'b1; b_start = 1'b1;
        cyc();
        a_start = 1'b0; b_start = 1'b0;
        w3 = 1'b0; n = 0;
        while (!a_done && n < 80) begin
            a_ready = n[0];
            a_we = 1'b0;
            if (a_valid && a_daddr == 3'd3 && !a_ready && !w3) begin
                a_we = 1'b1; a_wr = 3'd3; a_wd = 8'd99; w3 = 1'b1;
            end else if (a_valid && a_daddr == 3'd3 && a_ready) begin
                a_we = 1'b1; a_wr = 3'd4; a_wd = 8'd44;
            end else if (a_valid && a_daddr == 3'd4 && !a_ready) begin
                a_we = 1'b1; a_wr = 3'd5; a_wd = 8'd77;
            end
            cyc();
            n++;
        end
        a_we = 1'b0;
        chk("A_dump_done_seen", 32'(a_done), 1);
        chk("A_beat3_stalled_write", 32'(w3), 1);
        chk("A_queue_empty_after_dump", qa.size(), 0);

        // back-to-back dump requested in the DONE cycle, then reset mid-dump
        a_start = 1'b1; a_ready = 1'b1;
        cyc();
        a_start = 1'b0;
        n = 0;
        while (!(a_valid && a_daddr == 3'd2) && n < 20) begin cyc(); n++; end
        chk("A_second_dump_beat2", 32'(a_valid && a_daddr == 3'd2), 1);
        #2;
        RESET = 1'b0;
        #1;
        chk("A_reset_mid_dump", {a_valid, a_busy, a_done, 5'(a_daddr), a_ddata}, 0);
        chk("B_reset_mid_dump", {b_valid, b_busy, b_done, b_daddr, b_ddata}, 0);
        a_r1 = 3'd5; #1;
        chk("A_reset_clears_regs", 32'(a_o1), 0);
        cyc();
        RESET = 1'b1;
        for (int c = 0; c < 3; c++) cyc();

        // fresh dumps after reset: all-zero beats, full 16 beats on B
        a_start = 1'b1; b_start = 1'b1;
        cyc();
        a_start = 1'b0; b_start = 1'b0;
        n = 0;
        while ((a_busy || b_busy) && n < 200) begin
            b_ready = 1'($urandom);
            cyc();
            n++;
        end
        chk("final_dumps_timeout", 32'(a_busy || b_busy), 0);
        cyc();
        chk("A_queue_empty_end", qa.size(), 0);
        chk("B_queue_empty_end", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
